// File: rtl/fp_int_cvt_pkg.sv
// Shared definitions for the fp32 <-> int32 converter: field widths, op encodings,
// integer limits and the stage-1 pipeline register layout.
package fp_int_cvt_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;

  localparam logic [1:0] CVT_S_W  = 2'b00;
  localparam logic [1:0] CVT_S_WU = 2'b01;
  localparam logic [1:0] CVT_W_S  = 2'b10;
  localparam logic [1:0] CVT_WU_S = 2'b11;

  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

  // val holds the normalised magnitude (int->fp) or {8'b0, 1, frac} (fp->int)
  typedef struct packed {
    logic [1:0]  op;
    logic        sign;
    logic [31:0] val;
    logic [5:0]  lzc;
    logic [9:0]  e;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        sub_nz;
  } s1_t;

  function automatic logic is_f2i(input logic [1:0] op);
    return (op == CVT_W_S) || (op == CVT_WU_S);
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return (op == CVT_S_W) || (op == CVT_W_S);
  endfunction

endpackage

// File: rtl/fp_lzc32.sv
// 32-bit leading-zero counter with left-shift normaliser; count is 32 for a zero input.
module fp_lzc32 (
  input  logic [31:0] val,
  output logic [31:0] norm,
  output logic [5:0]  cnt
);

  // Scan upward so the highest set bit writes last
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++)
      if (val[i]) cnt = 6'(31 - i);
  end

  assign norm = val << cnt;

endmodule

// File: rtl/fp_int_cvt.sv
// Two-stage fp32 <-> int32 converter (fcvt.s.w/.s.wu/.w.s/.wu.s) with valid/ready on both sides.
// Define FP_CVT_RNE_EN for round-to-nearest-even; otherwise truncation.
module fp_int_cvt
  import fp_int_cvt_pkg::*;
#(
  parameter bit PIPE_OUT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [1:0]  o_flags
);

  logic             f2i_in, neg_in;
  logic [31:0]      mag, mag_norm;
  logic [5:0]       mag_lzc;
  logic [EXP_W-1:0] exp_in;
  logic [FRAC_W-1:0] frac_in;
  s1_t              s1_d, s1_q;
  logic             s1_valid, s2_adv;

  assign exp_in  = i_data[30:23];
  assign frac_in = i_data[22:0];
  assign f2i_in  = is_f2i(i_op);
  assign neg_in  = i_data[31] & is_signed(i_op);
  assign mag     = neg_in ? -i_data : i_data;

  fp_lzc32 u_lzc (
    .val  (mag),
    .norm (mag_norm),
    .cnt  (mag_lzc)
  );

  always_comb begin
    s1_d        = '0;
    s1_d.op     = i_op;
    s1_d.sign   = f2i_in ? i_data[31] : neg_in;
    s1_d.val    = f2i_in ? {8'd0, 1'b1, frac_in} : mag_norm;
    s1_d.lzc    = mag_lzc;
    s1_d.e      = {2'b00, exp_in} - 10'(FP_BIAS);
    s1_d.nan    = (&exp_in) & (|frac_in);
    s1_d.inf    = (&exp_in) & ~(|frac_in);
    s1_d.zero   = ~(|exp_in);
    s1_d.sub_nz = ~(|exp_in) & (|frac_in);
  end

  assign o_ready = !s1_valid | s2_adv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) s1_q <= s1_d;
    end
  end

  // Stage 2 datapath
  logic [23:0]       mant;
  logic              grd, stk, rnd;
  logic [24:0]       mant_r;
  logic [7:0]        exp_r;
  logic signed [9:0] e_s;
  logic [5:0]        shamt;
  logic [63:0]       fixed;
  logic [31:0]       ipart;
  logic              fgrd, fstk, frnd, big, ovf;
  logic [32:0]       mag33, lim;
  logic [31:0]       res;
  logic [1:0]        flg;

  always_comb begin
    // int->fp: hidden bit at val[31], guard/sticky in the low byte
    mant   = s1_q.val[31:8];
    grd    = s1_q.val[7];
    stk    = |s1_q.val[6:0];
`ifdef FP_CVT_RNE_EN
    rnd    = grd & (stk | mant[0]);
`else
    rnd    = 1'b0;
`endif
    mant_r = {1'b0, mant} + {24'd0, rnd};
    exp_r  = 8'd158 - {2'b00, s1_q.lzc} + {7'd0, mant_r[24]};

    // fp->int: place {1,frac} in a 32.32 fixed-point word
    e_s   = $signed(s1_q.e);
    shamt = s1_q.e[5:0] + 6'd9;
    fixed = {40'd0, s1_q.val[23:0]} << shamt;
    if (e_s < -10'sd1) begin
      ipart = '0;
      fgrd  = 1'b0;
      fstk  = 1'b1;
    end else begin
      ipart = fixed[63:32];
      fgrd  = fixed[31];
      fstk  = |fixed[30:0];
    end
`ifdef FP_CVT_RNE_EN
    frnd = fgrd & (fstk | ipart[0]);
`else
    frnd = 1'b0;
`endif
    mag33 = {1'b0, ipart} + {32'd0, frnd};
    big   = s1_q.inf | (e_s >= 10'sd32);
    // lim doubles as the magnitude bound and the saturated result
    if (s1_q.sign) lim = is_signed(s1_q.op) ? {1'b0, INT32_MIN} : 33'd0;
    else           lim = is_signed(s1_q.op) ? {1'b0, INT32_MAX} : {1'b0, UINT32_MAX};
    ovf = big | (mag33 > lim);

    res = '0;
    flg = '0;
    if (!is_f2i(s1_q.op)) begin
      if (|mant_r[24:23]) begin
        res    = {s1_q.sign, exp_r, mant_r[22:0]};
        flg[0] = grd | stk;
      end
    end else if (s1_q.nan) begin
      res = is_signed(s1_q.op) ? INT32_MAX : UINT32_MAX;
      flg = 2'b10;
    end else if (s1_q.zero) begin
      flg[0] = s1_q.sub_nz;
    end else if (ovf) begin
      res = lim[31:0];
      flg = 2'b10;
    end else begin
      res    = s1_q.sign ? -mag33[31:0] : mag33[31:0];
      flg[0] = fgrd | fstk;
    end
  end

  generate
    if (PIPE_OUT) begin : g_reg
      logic        s2_valid;
      logic [31:0] res_q;
      logic [1:0]  flg_q;

      assign s2_adv = !s2_valid | i_ready;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s2_valid <= 1'b0;
          res_q    <= '0;
          flg_q    <= '0;
        end else if (s2_adv) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            res_q <= res;
            flg_q <= flg;
          end
        end
      end

      assign o_valid  = s2_valid;
      assign o_result = res_q;
      assign o_flags  = flg_q;
    end else begin : g_comb
      assign s2_adv   = i_ready;
      assign o_valid  = s1_valid;
      assign o_result = res;
      assign o_flags  = flg;
    end
  endgenerate

endmodule

// File: tb/tb_fp_int_cvt.sv
// Directed bench for fp_int_cvt (PIPE_OUT=1); FP_CVT_RNE_EN selects the rounding expectations.
module tb_fp_int_cvt;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [1:0]  i_op, o_flags;
  logic [31:0] i_data, o_result;

  int n_chk  = 0;
  int n_pass = 0;

  fp_int_cvt #(.PIPE_OUT(1'b1)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flags  (o_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request, drained immediately; reports accept-to-valid latency in cycles
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] data,
                     input logic [31:0] eres, input logic [1:0] eflg, output int lat);
    bit acc;
    @(negedge i_clk);
    i_op = op; i_data = data; i_valid = 1'b1; i_ready = 1'b1;
    #1;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_ready) begin acc = 1'b1; break; end
      @(negedge i_clk); #1;
    end
    check({tag, "_acc"}, 32'(acc), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk); #1;
      lat++;
    end
    check({tag, "_vld"}, 32'(o_valid), 32'd1);
    check({tag, "_res"}, o_result, eres);
    check({tag, "_flg"}, 32'(o_flags), 32'(eflg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int got;
    bit acc, seen;
    logic [31:0] outs [3];

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_op = 2'b00; i_data = '0;
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_vld", 32'(o_valid), 32'd0);
    check("rst_rdy", 32'(o_ready), 32'd1);
    check("rst_res", o_result, 32'd0);
    check("rst_flg", 32'(o_flags), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // int -> fp
    run("i2f_one", 2'b00, 32'h0000_0001, 32'h3F80_0000, 2'b00, lat);
    check("i2f_lat", 32'(lat), 32'd2);
    run("i2f_m1",   2'b00, 32'hFFFF_FFFF, 32'hBF80_0000, 2'b00, lat);
    run("i2f_min",  2'b00, 32'h8000_0000, 32'hCF00_0000, 2'b00, lat);
    run("i2fu_big", 2'b01, 32'h8000_0000, 32'h4F00_0000, 2'b00, lat);
    run("i2f_zero", 2'b00, 32'h0000_0000, 32'h0000_0000, 2'b00, lat);
`ifdef FP_CVT_RNE_EN
    run("i2f_rnd",  2'b00, 32'h0100_0003, 32'h4B80_0002, 2'b01, lat);
    run("i2fu_max", 2'b01, 32'hFFFF_FFFF, 32'h4F80_0000, 2'b01, lat);
`else
    run("i2f_rnd",  2'b00, 32'h0100_0003, 32'h4B80_0001, 2'b01, lat);
    run("i2fu_max", 2'b01, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 2'b01, lat);
`endif

    // fp -> int
    run("f2i_pi",   2'b10, 32'h4049_0FDB, 32'd3, 2'b01, lat);
    run("f2i_2p5",  2'b10, 32'h4020_0000, 32'd2, 2'b01, lat);
`ifdef FP_CVT_RNE_EN
    run("f2i_3p5",  2'b10, 32'h4060_0000, 32'd4, 2'b01, lat);
    run("f2i_m3p5", 2'b10, 32'hC060_0000, 32'hFFFF_FFFC, 2'b01, lat);
`else
    run("f2i_3p5",  2'b10, 32'h4060_0000, 32'd3, 2'b01, lat);
    run("f2i_m3p5", 2'b10, 32'hC060_0000, 32'hFFFF_FFFD, 2'b01, lat);
`endif
    run("f2i_nan",  2'b10, 32'h7FC0_0000, 32'h7FFF_FFFF, 2'b10, lat);
    run("f2i_ovf",  2'b10, 32'h4F00_0000, 32'h7FFF_FFFF, 2'b10, lat);
    run("f2i_min",  2'b10, 32'hCF00_0000, 32'h8000_0000, 2'b00, lat);
    run("f2i_ninf", 2'b10, 32'hFF80_0000, 32'h8000_0000, 2'b10, lat);
    run("f2i_sub",  2'b10, 32'h0000_0001, 32'h0000_0000, 2'b01, lat);
    run("f2iu_m1",  2'b11, 32'hBF80_0000, 32'h0000_0000, 2'b10, lat);
    run("f2iu_mh",  2'b11, 32'hBF00_0000, 32'h0000_0000, 2'b01, lat);
    run("f2iu_inf", 2'b11, 32'h7F80_0000, 32'hFFFF_FFFF, 2'b10, lat);
    run("f2iu_nan", 2'b11, 32'h7FC0_0000, 32'hFFFF_FFFF, 2'b10, lat);
    run("f2iu_2p32",2'b11, 32'h4F80_0000, 32'hFFFF_FFFF, 2'b10, lat);
    run("f2iu_top", 2'b11, 32'h4F7F_FFFF, 32'hFFFF_FF00, 2'b00, lat);

    // Backpressure: third request stalls, results held, then drain in order
    @(negedge i_clk);
    i_ready = 1'b0; i_op = 2'b00; i_data = 32'd1; i_valid = 1'b1;
    #1; check("hs_rdy0", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_data = 32'd2;
    #1; check("hs_rdy1", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_data = 32'd3;
    #1;
    check("hs_rdy2", 32'(o_ready), 32'd0);
    check("hs_vld",  32'(o_valid), 32'd1);
    check("hs_hold0", o_result, 32'h3F80_0000);
    @(negedge i_clk);
    #1;
    check("hs_hold1", o_result, 32'h3F80_0000);
    check("hs_rdy3", 32'(o_ready), 32'd0);
    i_ready = 1'b1;
    #1;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      if (got < 3 && o_valid) begin
        outs[got] = o_result;
        got++;
      end
      acc = i_valid & o_ready;
      @(negedge i_clk);
      if (acc) i_valid = 1'b0;
      #1;
    end
    check("hs_count", 32'(got), 32'd3);
    check("hs_out0", outs[0], 32'h3F80_0000);
    check("hs_out1", outs[1], 32'h4000_0000);
    check("hs_out2", outs[2], 32'h4040_0000);

    // Reset with both stages occupied
    @(negedge i_clk);
    i_ready = 1'b0; i_op = 2'b00; i_data = 32'd5; i_valid = 1'b1;
    @(negedge i_clk);
    i_data = 32'd6;
    @(negedge i_clk);
    #1;
    check("rf_full_vld", 32'(o_valid), 32'd1);
    check("rf_full_rdy", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("rf_vld", 32'(o_valid), 32'd0);
    check("rf_rdy", 32'(o_ready), 32'd1);
    check("rf_res", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge i_clk); #1;
      if (o_valid) seen = 1'b1;
    end
    check("rf_drain", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
